// File: rtl/stage_wb_unit_if.sv
// rtl/stage_wb_unit_if.sv - MEM/WB slot and regfile write-port bundle for stage_wb_unit
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

interface stage_wb_unit_if #(
  parameter int REG_WIDTH = `REG_WIDTH,
  parameter int RD_WIDTH  = 5,
  parameter int CNT_WIDTH = 64
);
  localparam int OFF_WIDTH = $clog2(REG_WIDTH/8);

  logic                 MEM_WB_valid;
  logic                 MEM_WB_reg_wen;
  logic [RD_WIDTH-1:0]  MEM_WB_rd;
  logic [1:0]           MEM_WB_reg_wb_sel;
  logic [2:0]           MEM_WB_funct3;
  logic [OFF_WIDTH-1:0] MEM_WB_byte_off;
  logic [REG_WIDTH-1:0] MEM_WB_alu_out;
  logic [REG_WIDTH-1:0] MEM_WB_data_out;
  logic [REG_WIDTH-1:0] MEM_WB_pc_plus4;
  logic [REG_WIDTH-1:0] MEM_WB_csr_rdata;
  logic                 WB_stall;
  logic                 WB_flush;
  logic [REG_WIDTH-1:0] WB_data;
  logic [RD_WIDTH-1:0]  WB_rd;
  logic                 WB_wen;
  logic                 WB_misalign;
  logic [CNT_WIDTH-1:0] WB_instret;

  modport master (
    output MEM_WB_valid, MEM_WB_reg_wen, MEM_WB_rd, MEM_WB_reg_wb_sel, MEM_WB_funct3,
           MEM_WB_byte_off, MEM_WB_alu_out, MEM_WB_data_out, MEM_WB_pc_plus4,
           MEM_WB_csr_rdata, WB_stall, WB_flush,
    input  WB_data, WB_rd, WB_wen, WB_misalign, WB_instret
  );

  modport slave (
    input  MEM_WB_valid, MEM_WB_reg_wen, MEM_WB_rd, MEM_WB_reg_wb_sel, MEM_WB_funct3,
           MEM_WB_byte_off, MEM_WB_alu_out, MEM_WB_data_out, MEM_WB_pc_plus4,
           MEM_WB_csr_rdata, WB_stall, WB_flush,
    output WB_data, WB_rd, WB_wen, WB_misalign, WB_instret
  );
endinterface

// File: rtl/stage_wb_unit.sv
// rtl/stage_wb_unit.sv - write-back stage: source select, load align/extend, registered regfile port
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module stage_wb_unit #(
  parameter int REG_WIDTH = `REG_WIDTH,
  parameter int RD_WIDTH  = 5,
  parameter int CNT_WIDTH = 64
) (
  input  logic           clk,
  input  logic           reset_n,
  stage_wb_unit_if.slave bus
);
  localparam bit IS64 = (REG_WIDTH == 64);

  logic [REG_WIDTH-1:0] lane;
  logic [REG_WIDTH-1:0] load_data;
  logic [REG_WIDTH-1:0] sel_data;
  logic                 misalign;
  logic                 wen_next;

  logic [REG_WIDTH-1:0] data_q;
  logic [RD_WIDTH-1:0]  rd_q;
  logic                 wen_q;
  logic                 misalign_q;
  logic [CNT_WIDTH-1:0] instret_q;

  always_comb lane = bus.MEM_WB_data_out >> {bus.MEM_WB_byte_off, 3'b000};

  always_comb begin
    load_data = '0;
    case (bus.MEM_WB_funct3)
      3'b000:  load_data = REG_WIDTH'($signed(lane[7:0]));
      3'b001:  load_data = REG_WIDTH'($signed(lane[15:0]));
      3'b010:  load_data = REG_WIDTH'($signed(lane[31:0]));
      3'b100:  load_data = REG_WIDTH'(lane[7:0]);
      3'b101:  load_data = REG_WIDTH'(lane[15:0]);
      3'b110:  if (IS64) load_data = REG_WIDTH'(lane[31:0]);
      3'b011:  if (IS64) load_data = lane;
      default: load_data = '0;
    endcase
  end

  // 64-bit-only codes are treated as unknown loads on a 32-bit build, so they never flag
  always_comb begin
    misalign = 1'b0;
    if (bus.MEM_WB_reg_wb_sel == 2'b00) begin
      case (bus.MEM_WB_funct3)
        3'b001, 3'b101: misalign = bus.MEM_WB_byte_off[0];
        3'b010:         misalign = |bus.MEM_WB_byte_off[1:0];
        3'b110:         misalign = IS64 && (|bus.MEM_WB_byte_off[1:0]);
        3'b011:         misalign = IS64 && (|bus.MEM_WB_byte_off);
        default:        misalign = 1'b0;
      endcase
    end
  end

  always_comb begin
    sel_data = load_data;
    case (bus.MEM_WB_reg_wb_sel)
      2'b01:   sel_data = bus.MEM_WB_alu_out;
      2'b10:   sel_data = bus.MEM_WB_pc_plus4;
      2'b11:   sel_data = bus.MEM_WB_csr_rdata;
      default: sel_data = load_data;
    endcase
  end

  always_comb wen_next = bus.MEM_WB_reg_wen & (bus.MEM_WB_rd != '0) & ~misalign;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= '0;
      rd_q       <= '0;
      wen_q      <= 1'b0;
      misalign_q <= 1'b0;
      instret_q  <= '0;
    end else begin
      misalign_q <= 1'b0;
      if (bus.WB_flush) begin
        wen_q <= 1'b0;
      end else if (bus.WB_stall) begin
        wen_q <= wen_q;
      end else if (bus.MEM_WB_valid) begin
        data_q     <= sel_data;
        rd_q       <= bus.MEM_WB_rd;
        wen_q      <= wen_next;
        misalign_q <= misalign;
        instret_q  <= instret_q + 1'b1;
      end else begin
        wen_q <= 1'b0;
      end
    end
  end

  assign bus.WB_data     = data_q;
  assign bus.WB_rd       = rd_q;
  assign bus.WB_wen      = wen_q;
  assign bus.WB_misalign = misalign_q;
  assign bus.WB_instret  = instret_q;
endmodule
